bus_copy_master: RTL and testbench

Word-copy bus initiator for the memory-mapped peripheral bus, the initiator-side counterpart of the peripheral block's `rd`/`wr`/`addr`/`wdata`/`rdata` responder port. When started, it moves `len` 32-bit words from a source address range to a destination address range through ordinary bus read/write cycles, then signals completion. It sits beside the CPU core as a second bus master. An external arbiter grants it the bus while `busy` is high.

---
 rtl/bus_copy_master.sv | 124 ++++++++++++
 tb/tb_bus_copy_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_copy_master.sv
// Bus initiator that copies len 32-bit words from src to dst using read/write cycles.
// Optional completion interrupt register enabled by defining BUS_COPY_IRQ_EN.
module bus_copy_master #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             rd,
    output logic             wr,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    input  logic             irq_ack,
    output logic             irqout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        src_ptr_reg, src_ptr_next;
    logic [31:0]        dst_ptr_reg, dst_ptr_next;
    logic [LEN_W-1:0]   count_reg, count_next;
    logic [31:0]        data_buf_reg, data_buf_next;

    // Word alignment discards the low address bits.
    logic [3:0] unused_low_bits;
    assign unused_low_bits = {src[1:0], dst[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            src_ptr_reg  <= 32'h0;
            dst_ptr_reg  <= 32'h0;
            count_reg    <= '0;
            data_buf_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            src_ptr_reg  <= src_ptr_next;
            dst_ptr_reg  <= dst_ptr_next;
            count_reg    <= count_next;
            data_buf_reg <= data_buf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        src_ptr_next  = src_ptr_reg;
        dst_ptr_next  = dst_ptr_reg;
        count_next    = count_reg;
        data_buf_next = data_buf_reg;
        busy          = 1'b0;
        done          = 1'b0;
        rd            = 1'b0;
        wr            = 1'b0;
        addr          = 32'h0;
        wdata         = 32'h0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_ptr_next = {src[31:2], 2'b00};
                    dst_ptr_next = {dst[31:2], 2'b00};
                    count_next   = len;
                    state_next   = (len != '0) ? READ : FINISH;
                end
            end
            READ: begin
                busy          = 1'b1;
                rd            = 1'b1;
                addr          = src_ptr_reg;
                data_buf_next = rdata;
                state_next    = WRITE;
            end
            WRITE: begin
                busy         = 1'b1;
                wr           = 1'b1;
                addr         = dst_ptr_reg;
                wdata        = data_buf_reg;
                // Pointers wrap modulo 2^32 by plain 32-bit addition.
                src_ptr_next = src_ptr_reg + 32'd4;
                dst_ptr_next = dst_ptr_reg + 32'd4;
                count_next   = count_reg - LEN_W'(1);
                state_next   = (count_reg == LEN_W'(1)) ? FINISH : READ;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BUS_COPY_IRQ_EN
    logic irq_reg;

    // Setting on the FINISH exit edge takes priority over a simultaneous ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_reg <= 1'b0;
        end else if (state_reg == FINISH) begin
            irq_reg <= 1'b1;
        end else if (irq_ack) begin
            irq_reg <= 1'b0;
        end
    end

    assign irqout = irq_reg;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irqout         = 1'b0;
`endif

endmodule

// File: tb/tb_bus_copy_master.sv
// Self-checking bench for bus_copy_master: directed and random copies against a word-level model.
// Expects the interrupt only when BUS_COPY_IRQ_EN is defined for the build.
module tb_bus_copy_master;

    localparam int LEN_W = 8;

`ifdef BUS_COPY_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src = 32'h0;
    logic [31:0]      dst = 32'h0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, rd, wr, irqout;
    logic [31:0]      addr, wdata, rdata;
    logic             irq_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    // Bus responder memory (256 words, aliased by address bits [9:2]) and the model's copy of it.
    logic [31:0] mem       [0:255];
    logic [31:0] model_mem [0:255];
    logic [31:0] exp_src   [0:255];
    logic [31:0] exp_dst   [0:255];
    logic [31:0] exp_data  [0:255];

    bus_copy_master #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq_ack(irq_ack), .irqout(irqout)
    );

    always #5 clk = ~clk;

    assign rdata = mem[addr[9:2]];

    always @(posedge clk) begin
        if (wr) mem[addr[9:2]] <= wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word-level model: each word is read from the source then written to the destination, ascending.
    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa, da;
        for (int i = 0; i < n; i++) begin
            sa = {s[31:2], 2'b00} + 32'(4 * i);
            da = {d[31:2], 2'b00} + 32'(4 * i);
            exp_src[i]  = sa;
            exp_dst[i]  = da;
            exp_data[i] = model_mem[sa[9:2]];
            model_mem[da[9:2]] = exp_data[i];
        end
    endtask

    // Cycle c after the start edge of an n-word copy: odd cycles read word (c-1)/2, even cycles write it.
    task automatic check_cycle(input string tag, input int c, input int n, input logic e_irq);
        logic e_rd, e_wr, e_busy, e_done;
        logic [31:0] e_addr, e_wdata;
        int w;
        e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0; e_addr = 0; e_wdata = 0;
        if (c <= 2 * n) begin
            w = (c - 1) / 2;
            e_busy = 1;
            if (c % 2 == 1) begin
                e_rd = 1;
                e_addr = exp_src[w];
            end else begin
                e_wr = 1;
                e_addr = exp_dst[w];
                e_wdata = exp_data[w];
            end
        end else if (c == 2 * n + 1) begin
            e_done = 1;
        end
        chk($sformatf("%s c%0d rd", tag, c), 32'(rd), 32'(e_rd));
        chk($sformatf("%s c%0d wr", tag, c), 32'(wr), 32'(e_wr));
        chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(e_busy));
        chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(e_done));
        chk($sformatf("%s c%0d addr", tag, c), addr, e_addr);
        if (!e_rd) chk($sformatf("%s c%0d wdata", tag, c), wdata, e_wdata);
        chk($sformatf("%s c%0d irqout", tag, c), 32'(irqout), 32'(e_irq));
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            check_cycle(tag, 1000 + k, 0, 1'b0);
            @(negedge clk);
        end
    endtask

    // Runs one copy from a negedge; optional extra start pulse in cycle inject, optional ack held throughout.
    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int inject, input logic hold_ack);
        plan(s, d, n);
        irq_ack = hold_ack;
        src = s; dst = d; len = LEN_W'(n); start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 2 * n + 1; c++) begin
            check_cycle(tag, c, n, 1'b0);
            start = (c == inject);
            if (c == inject) begin
                src = $urandom; dst = $urandom; len = LEN_W'(5);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_cycle(tag, 2 * n + 2, n, IRQ_ON);
        irq_ack = 1'b1;
        @(negedge clk);
        check_cycle(tag, 2 * n + 3, n, 1'b0);
        irq_ack = 1'b0;
        @(negedge clk);
        check_cycle(tag, 2 * n + 4, n, 1'b0);
        $display("copy %s src=%h dst=%h len=%0d", tag, s, d, n);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
        end
        mem[8'h40] = 32'hA; mem[8'h41] = 32'hB; mem[8'h42] = 32'hC;
        for (int i = 0; i < 256; i++) model_mem[i] = mem[i];

        // Reset held for three cycles, then idle.
        repeat (3) @(negedge clk);
        check_cycle("reset", 1000, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("idle", 10);
        $display("reset/idle done");

        run_copy("basic", 32'h100, 32'h200, 3, 0, 1'b0);
        run_copy("zero", 32'h500, 32'h600, 0, 0, 1'b0);
        run_copy("wrap", 32'hFFFF_FFFD, 32'h0000_0003, 2, 0, 1'b0);
        run_copy("busy_start", 32'h180, 32'h1C0, 4, 4, 1'b0);
        check_idle("after_busy_start", 5);
        run_copy("ack_held", 32'h240, 32'h280, 2, 0, 1'b1);
        run_copy("overlap", 32'h300, 32'h304, 3, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_copy($sformatf("rand%0d", r), $urandom, $urandom, $urandom_range(1, 12), 0, 1'b0);
        end

        // Reset in the second READ of a 4-word copy; only the first word has been written.
        plan(32'h340, 32'h3A0, 1);
        src = 32'h340; dst = 32'h3A0; len = LEN_W'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cycle("rst_mid", 1, 1, 1'b0);
        @(negedge clk);
        check_cycle("rst_mid", 2, 1, 1'b0);
        @(negedge clk);
        chk("rst_mid c3 rd", 32'(rd), 32'd1);
        chk("rst_mid c3 addr", addr, 32'h344);
        reset = 1'b0;
        #1;
        chk("rst_mid async rd", 32'(rd), 32'd0);
        chk("rst_mid async busy", 32'(busy), 32'd0);
        chk("rst_mid async addr", addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("after_rst", 5);
        $display("reset mid-transfer done");

        run_copy("post_rst", 32'h3A0, 32'h3E0, 2, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
